// File: rtl/light_phase_timer.sv
// light_phase_timer: one-second prescaler plus per-phase seconds counter
// that drives the traffic-light controller's max_r / max_g / max_y inputs.
// Optional feature: define PED_EXTEND_EN to add the ped input and a
// pedestrian request latch that stretches the red phase by PED_SEC seconds.
module light_phase_timer #(
   parameter int TICK_DIV   = 50000000,
   parameter int CNT_W      = 4,
   parameter int RED_SEC    = 6,
   parameter int GREEN_SEC  = 4,
   parameter int YELLOW_SEC = 2,
   parameter int PED_SEC    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic red,
   input  logic green,
   input  logic yellow,
`ifdef PED_EXTEND_EN
   input  logic ped,
`endif
   output logic tick,
   output logic max_r,
   output logic max_g,
   output logic max_y
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] SEC_SAT  = '1;
   localparam logic [CNT_W-1:0] RED_LIM  = CNT_W'(RED_SEC);
   localparam logic [CNT_W-1:0] GRN_LIM  = CNT_W'(GREEN_SEC);
   localparam logic [CNT_W-1:0] YEL_LIM  = CNT_W'(YELLOW_SEC);

   // Reject parameter sets the counters cannot represent.
   generate
      if (TICK_DIV < 2) begin : g_bad_div
         $error("light_phase_timer: TICK_DIV must be at least 2");
      end
      if (RED_SEC + PED_SEC > (2 ** CNT_W) - 1) begin : g_bad_width
         $error("light_phase_timer: CNT_W too narrow for RED_SEC + PED_SEC");
      end
   endgenerate

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] sec_q, sec_d;
   logic             max_r_q, max_r_d;
   logic             max_g_q, max_g_d;
   logic             max_y_q, max_y_d;
   logic             one_hot;
   logic [CNT_W-1:0] red_lim;

`ifdef PED_EXTEND_EN
   localparam logic [CNT_W-1:0] RED_PED_LIM = CNT_W'(RED_SEC + PED_SEC);
   logic ped_q, ped_d;

   // Pedestrian latch: restart clears it and wins over a new request.
   always_comb begin
      ped_d = ped_q;
      if (restart) begin
         ped_d = 1'b0;
      end else if (ped && red && !max_r_q) begin
         ped_d = 1'b1;
      end
   end

   // Pedestrian latch register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ped_q <= 1'b0;
      end else begin
         ped_q <= ped_d;
      end
   end

   assign red_lim = ped_q ? RED_PED_LIM : RED_LIM;
`else
   assign red_lim = RED_LIM;
`endif

   // tick is decoded from the registered prescaler; a restart suppresses it.
   assign tick = (pre_q == PRE_LAST) && !restart;

   // Exactly one phase input must be active for any expiry to be reported.
   always_comb begin
      one_hot = 1'b0;
      case ({red, green, yellow})
         3'b100, 3'b010, 3'b001: one_hot = 1'b1;
         default:                one_hot = 1'b0;
      endcase
   end

   // Next state for prescaler, saturating seconds counter and expiry flags.
   always_comb begin
      pre_d = pre_q;
      sec_d = sec_q;
      if (restart) begin
         pre_d = '0;
         sec_d = '0;
      end else begin
         pre_d = tick ? '0 : pre_q + PRE_W'(1);
         if (tick && sec_q != SEC_SAT) begin
            sec_d = sec_q + CNT_W'(1);
         end
      end
      max_r_d = red    && one_hot && (sec_q >= red_lim) && !restart;
      max_g_d = green  && one_hot && (sec_q >= GRN_LIM) && !restart;
      max_y_d = yellow && one_hot && (sec_q >= YEL_LIM) && !restart;
   end

   // State registers; reset aborts any count in progress immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q   <= '0;
         sec_q   <= '0;
         max_r_q <= 1'b0;
         max_g_q <= 1'b0;
         max_y_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         sec_q   <= sec_d;
         max_r_q <= max_r_d;
         max_g_q <= max_g_d;
         max_y_q <= max_y_d;
      end
   end

   assign max_r = max_r_q;
   assign max_g = max_g_q;
   assign max_y = max_y_q;

endmodule
